// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Pipeline front end. Owns the PC, keeps at most one instruction
//            memory request in flight, and buffers the returned word for the
//            IF/ID register. Also drives the IF/ID load-enable and flush.
// Ports    : clk, Reset            - clock, async active-high reset
//            Stall                 - ID hazard, IF/ID must hold
//            Redirect, Redirect_Target - taken branch/jump, new PC
//            imem_req/imem_addr    - fetch request strobe and address
//            imem_valid/imem_rdata - in-order response strobe and data
//            Instr_Out/PCOG_Out/PC4_Out - buffered instruction, its PC, PC+4
//            IF_ID_LE/IF_ID_Flush  - IF/ID load enable and flush
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_Out,
  output logic [31:0] PCOG_Out,
  output logic [31:0] PC4_Out,
  output logic        IF_ID_LE,
  output logic        IF_ID_Flush
);

  localparam logic [31:0] RESET_PC4 = RESET_PC + 32'd4;

  // FETCH: issue request; WAIT: response pending; HOLD: word buffered for
  // IF/ID; DROP: response pending but already invalidated by a redirect.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcog_q, pcog_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] redirect_pc;

  // Redirect targets are forced to word alignment.
  assign redirect_pc = {Redirect_Target[31:2], 2'b00};

  // Reset gating keeps the strobes low for the whole time Reset is high,
  // independent of what Redirect/Stall are doing.
  assign imem_req    = (state_q == S_FETCH) & ~Redirect & ~Reset;
  assign imem_addr   = pc_q;
  assign IF_ID_LE    = (state_q == S_HOLD) & ~Stall & ~Redirect & ~Reset;
  assign IF_ID_Flush = Redirect & ~Reset;

  assign Instr_Out = instr_q;
  assign PCOG_Out  = pcog_q;
  assign PC4_Out   = pc4_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcog_d  = pcog_q;
    pc4_d   = pc4_q;

    if (Redirect) begin
      // Redirect overrides stall and every normal transition. An in-flight
      // response is still owed by memory, so it must be absorbed (DROP)
      // unless it arrives in this very cycle.
      pc_d = redirect_pc;
      case (state_q)
        S_FETCH: state_d = S_FETCH;
        S_WAIT:  state_d = imem_valid ? S_FETCH : S_DROP;
        S_HOLD: begin
          instr_d = NOP_INSTR;
          state_d = S_FETCH;
        end
        S_DROP:  state_d = imem_valid ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      // imem_valid outside WAIT/DROP is a protocol violation and is ignored.
      case (state_q)
        S_FETCH: begin
          if (imem_req) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr_d = imem_rdata;
            pcog_d  = pc_q;
            pc4_d   = pc_q + 32'd4;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (IF_ID_LE) begin
            pc_d    = pc_q + 32'd4;
            instr_d = NOP_INSTR;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_valid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcog_q  <= RESET_PC;
      pc4_q   <= RESET_PC4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcog_q  <= pcog_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed scenarios plus a randomized run checked against a
//            transaction-level model of the expected instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_Out;
  logic [31:0] PCOG_Out;
  logic [31:0] PC4_Out;
  logic        IF_ID_LE;
  logic        IF_ID_Flush;

  // Second instance exercising the wrap-around reset PC.
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [31:0] tgt2 = 32'h0;
  logic        imem_valid2;
  logic [31:0] imem_rdata2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] instr2, pcog2, pc4_2;
  logic        le2, flush2;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .Redirect_Target(Redirect_Target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .Instr_Out(Instr_Out),
    .PCOG_Out(PCOG_Out), .PC4_Out(PC4_Out), .IF_ID_LE(IF_ID_LE),
    .IF_ID_Flush(IF_ID_Flush)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .Reset(Reset), .Stall(stall2), .Redirect(redir2),
    .Redirect_Target(tgt2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .Instr_Out(instr2),
    .PCOG_Out(pcog2), .PC4_Out(pc4_2), .IF_ID_LE(le2), .IF_ID_Flush(flush2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Reference model state for the randomized run.
  logic [31:0] exp_pc;
  logic        pend;
  int          pend_delay;
  logic [31:0] pend_addr;
  logic        prev_redir;
  int          deliveries;

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_Target = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0; imem_valid2 = 1'b0; imem_rdata2 = 32'h0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_le", {31'b0, IF_ID_LE}, 32'd0);
    check("rst_flush", {31'b0, IF_ID_Flush}, 32'd0);
    check("rst_instr", Instr_Out, NOP);
    check("rst_pcog", PCOG_Out, 32'h0);
    check("rst_pc4", PC4_Out, 32'h4);
    check("rst_wrap_pcog", pcog2, 32'hFFFFFFFC);
    check("rst_wrap_pc4", pc4_2, 32'h0);

    // ---------------- basic fetch (and wrap instance) ----------------
    @(posedge clk); #1 Reset = 1'b0;
    @(negedge clk);
    check("t1_c0_req", {31'b0, imem_req}, 32'd1);
    check("t1_c0_addr", imem_addr, 32'h0);
    check("t5_c0_addr", imem_addr2, 32'hFFFFFFFC);
    @(posedge clk); #1;
    imem_valid = 1'b1; imem_rdata = 32'h00500093;
    imem_valid2 = 1'b1; imem_rdata2 = 32'h00100073;
    @(negedge clk);
    check("t1_c1_req", {31'b0, imem_req}, 32'd0);
    check("t1_c1_le", {31'b0, IF_ID_LE}, 32'd0);
    @(posedge clk); #1;
    imem_valid = 1'b0; imem_valid2 = 1'b0;
    @(negedge clk);
    check("t1_c2_le", {31'b0, IF_ID_LE}, 32'd1);
    check("t1_c2_instr", Instr_Out, 32'h00500093);
    check("t1_c2_pcog", PCOG_Out, 32'h0);
    check("t1_c2_pc4", PC4_Out, 32'h4);
    check("t5_le", {31'b0, le2}, 32'd1);
    check("t5_instr", instr2, 32'h00100073);
    check("t5_pcog", pcog2, 32'hFFFFFFFC);
    check("t5_pc4", pc4_2, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_c3_req", {31'b0, imem_req}, 32'd1);
    check("t1_c3_addr", imem_addr, 32'h4);
    check("t1_c3_instr", Instr_Out, NOP);
    check("t5_next_addr", imem_addr2, 32'h0);

    // ---------------- stall in HOLD ----------------
    @(posedge clk); #1 imem_valid = 1'b1; imem_rdata = 32'h00a00113;
    @(posedge clk); #1 imem_valid = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      check("t2_stall_le", {31'b0, IF_ID_LE}, 32'd0);
      check("t2_stall_instr", Instr_Out, 32'h00a00113);
      check("t2_stall_pcog", PCOG_Out, 32'h4);
    end
    @(posedge clk); #1 Stall = 1'b0;
    @(negedge clk);
    check("t2_release_le", {31'b0, IF_ID_LE}, 32'd1);
    check("t2_release_instr", Instr_Out, 32'h00a00113);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_next_req", {31'b0, imem_req}, 32'd1);
    check("t2_next_addr", imem_addr, 32'h8);

    // ---------------- redirect in WAIT, late response dropped ----------------
    @(posedge clk); #1 Redirect = 1'b1; Redirect_Target = 32'h100;
    @(negedge clk);
    check("t3_flush", {31'b0, IF_ID_Flush}, 32'd1);
    check("t3_le", {31'b0, IF_ID_LE}, 32'd0);
    @(posedge clk); #1 Redirect = 1'b0;
    @(negedge clk);
    check("t3_drop_req", {31'b0, imem_req}, 32'd0);
    check("t3_drop_flush", {31'b0, IF_ID_Flush}, 32'd0);
    @(posedge clk); #1 imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t3_resp_le", {31'b0, IF_ID_LE}, 32'd0);
    check("t3_resp_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(negedge clk);
    check("t3_next_req", {31'b0, imem_req}, 32'd1);
    check("t3_next_addr", imem_addr, 32'h100);
    check("t3_no_load", Instr_Out, NOP);
    check("t3_next_le", {31'b0, IF_ID_LE}, 32'd0);

    // ---------------- redirect + stall in HOLD ----------------
    @(posedge clk); #1 imem_valid = 1'b1; imem_rdata = 32'h00208133;
    @(posedge clk); #1 imem_valid = 1'b0; Stall = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h103;
    @(negedge clk);
    check("t4_le", {31'b0, IF_ID_LE}, 32'd0);
    check("t4_flush", {31'b0, IF_ID_Flush}, 32'd1);
    check("t4_instr_before", Instr_Out, 32'h00208133);
    @(posedge clk); #1 Stall = 1'b0; Redirect = 1'b0;
    @(negedge clk);
    check("t4_instr_nop", Instr_Out, NOP);
    check("t4_next_req", {31'b0, imem_req}, 32'd1);
    check("t4_next_addr", imem_addr, 32'h100);

    // ---------------- async reset mid-WAIT, stale response ----------------
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_wait_req", {31'b0, imem_req}, 32'd0);
    check("t6_wait_pcog", PCOG_Out, 32'h100);
    #2 Reset = 1'b1;
    #1;
    check("t6_async_pcog", PCOG_Out, 32'h0);
    check("t6_async_pc4", PC4_Out, 32'h4);
    check("t6_async_instr", Instr_Out, NOP);
    check("t6_async_req", {31'b0, imem_req}, 32'd0);
    check("t6_async_addr", imem_addr, 32'h0);
    @(posedge clk); #1 Reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hBADC0DE0;
    @(negedge clk);
    check("t6_stale_req", {31'b0, imem_req}, 32'd1);
    check("t6_stale_addr", imem_addr, 32'h0);
    check("t6_stale_le", {31'b0, IF_ID_LE}, 32'd0);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(posedge clk); #1 imem_valid = 1'b1; imem_rdata = 32'h00300193;
    @(negedge clk);
    check("t6_wait_le", {31'b0, IF_ID_LE}, 32'd0);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(negedge clk);
    check("t6_deliver_le", {31'b0, IF_ID_LE}, 32'd1);
    check("t6_deliver_instr", Instr_Out, 32'h00300193);
    check("t6_deliver_pcog", PCOG_Out, 32'h0);

    // ---------------- randomized run vs stream model ----------------
    @(posedge clk); #1 Reset = 1'b1;
    @(posedge clk); #1 Reset = 1'b0;
    exp_pc = 32'h0; pend = 1'b0; pend_delay = 0; pend_addr = 32'h0;
    prev_redir = 1'b0; deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      // memory side: answer the single outstanding request after its latency
      if (pend && pend_delay == 0) begin
        imem_valid = 1'b1;
        imem_rdata = memf(pend_addr);
        pend = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (pend) pend_delay--;
      end
      Stall    = ($urandom_range(0, 3) == 0);
      Redirect = !prev_redir && ($urandom_range(0, 9) == 0);
      Redirect_Target = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD : ($urandom & 32'h000003FF);
      prev_redir = Redirect;
      @(negedge clk);
      if (Redirect) begin
        check("r_flush", {31'b0, IF_ID_Flush}, 32'd1);
        check("r_redir_le", {31'b0, IF_ID_LE}, 32'd0);
        check("r_redir_req", {31'b0, imem_req}, 32'd0);
        exp_pc = {Redirect_Target[31:2], 2'b00};
      end else begin
        check("r_noflush", {31'b0, IF_ID_Flush}, 32'd0);
        if (Stall) check("r_stall_le", {31'b0, IF_ID_LE}, 32'd0);
        if (IF_ID_LE) begin
          check("r_instr", Instr_Out, memf(exp_pc));
          check("r_pcog", PCOG_Out, exp_pc);
          check("r_pc4", PC4_Out, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          deliveries++;
        end
        if (imem_req) begin
          check("r_one_outstanding", {31'b0, pend}, 32'd0);
          check("r_addr", imem_addr, exp_pc);
          pend = 1'b1;
          pend_addr = imem_addr;
          pend_delay = $urandom_range(0, 2);
        end
      end
    end
    check("r_progress", {31'b0, deliveries > 50}, 32'd1);
    Stall = 1'b0; Redirect = 1'b0; imem_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
